// File: rtl/parking_lot_counter_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : parking_lot_counter_if
// Purpose: Bundles the sensor inputs and occupancy/display outputs of the
//          parking-lot counter.
// Signals: a, b          raw outer/inner photo-sensor (1 = beam blocked)
//          ones, tens    BCD occupancy digits
//          clear, full   lot empty / lot at capacity
//          car_in, car_out, blocked  one-cycle event pulses
// Modports: master = sensor/display side, slave = counter
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
interface parking_lot_counter_if;
   logic       a;
   logic       b;
   logic [3:0] ones;
   logic [3:0] tens;
   logic       clear;
   logic       full;
   logic       car_in;
   logic       car_out;
   logic       blocked;

   modport master (
      output a, b,
      input  ones, tens, clear, full, car_in, car_out, blocked
   );

   modport slave (
      input  a, b,
      output ones, tens, clear, full, car_in, car_out, blocked
   );
endinterface
`default_nettype wire

// File: rtl/parking_lot_counter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : parking_lot_counter
// Purpose: Synchronizes two photo-sensors, decodes complete car entries and
//          exits with a direction FSM, and keeps a saturating BCD occupancy
//          count (0..MAX).
// Ports  : clk    system clock, rising edge
//          reset  asynchronous active-high reset
//          bus    parking_lot_counter_if.slave (a, b in; ones, tens, clear,
//                 full, car_in, car_out, blocked out)
// Params : MAX    lot capacity, 1..99
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module parking_lot_counter #(
   parameter int MAX = 25
) (
   input logic                   clk,
   input logic                   reset,
   parking_lot_counter_if.slave  bus
);

   // Capacity split into BCD digits so saturation is a direct digit compare.
   localparam logic [3:0] c_max_ones = 4'(MAX % 10);
   localparam logic [3:0] c_max_tens = 4'(MAX / 10);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ENT1 = 3'd1,
      S_ENT2 = 3'd2,
      S_ENT3 = 3'd3,
      S_EXT1 = 3'd4,
      S_EXT2 = 3'd5,
      S_EXT3 = 3'd6
   } t_state;

   logic       r_a_meta, r_a_s;
   logic       r_b_meta, r_b_s;
   t_state     r_state;
   logic [3:0] r_ones;
   logic [3:0] r_tens;
   logic       r_car_in;
   logic       r_car_out;
   logic       r_blocked;

   logic [1:0] w_ab;
   t_state     w_state_nxt;
   logic       w_entry;
   logic       w_exit;
   logic       w_at_max;
   logic       w_at_zero;

   // Two-flop synchronizers for the asynchronous sensor inputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_a_meta <= 1'b0;
         r_a_s    <= 1'b0;
         r_b_meta <= 1'b0;
         r_b_s    <= 1'b0;
      end else begin
         r_a_meta <= bus.a;
         r_a_s    <= r_a_meta;
         r_b_meta <= bus.b;
         r_b_s    <= r_b_meta;
      end
   end

   assign w_ab = {r_a_s, r_b_s};

   // Direction decode. Any sensor pattern not legal for the current state
   // drops back to IDLE without producing an event.
   always_comb begin
      w_state_nxt = S_IDLE;
      w_entry     = 1'b0;
      w_exit      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_ab == 2'b10)      w_state_nxt = S_ENT1;
            else if (w_ab == 2'b01) w_state_nxt = S_EXT1;
            else                    w_state_nxt = S_IDLE;
         end
         S_ENT1: begin
            if (w_ab == 2'b10)      w_state_nxt = S_ENT1;
            else if (w_ab == 2'b11) w_state_nxt = S_ENT2;
         end
         S_ENT2: begin
            if (w_ab == 2'b11)      w_state_nxt = S_ENT2;
            else if (w_ab == 2'b01) w_state_nxt = S_ENT3;
            else if (w_ab == 2'b10) w_state_nxt = S_ENT1;
         end
         S_ENT3: begin
            if (w_ab == 2'b01)      w_state_nxt = S_ENT3;
            else if (w_ab == 2'b11) w_state_nxt = S_ENT2;
            else if (w_ab == 2'b00) w_entry     = 1'b1;
         end
         S_EXT1: begin
            if (w_ab == 2'b01)      w_state_nxt = S_EXT1;
            else if (w_ab == 2'b11) w_state_nxt = S_EXT2;
         end
         S_EXT2: begin
            if (w_ab == 2'b11)      w_state_nxt = S_EXT2;
            else if (w_ab == 2'b10) w_state_nxt = S_EXT3;
            else if (w_ab == 2'b01) w_state_nxt = S_EXT1;
         end
         S_EXT3: begin
            if (w_ab == 2'b10)      w_state_nxt = S_EXT3;
            else if (w_ab == 2'b11) w_state_nxt = S_EXT2;
            else if (w_ab == 2'b00) w_exit      = 1'b1;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // The count never exceeds MAX, so equality is enough for saturation.
   assign w_at_max  = (r_tens == c_max_tens) && (r_ones == c_max_ones);
   assign w_at_zero = (r_tens == 4'd0) && (r_ones == 4'd0);

   // FSM state, BCD count and event pulses all update on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_ones    <= 4'd0;
         r_tens    <= 4'd0;
         r_car_in  <= 1'b0;
         r_car_out <= 1'b0;
         r_blocked <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_car_in  <= 1'b0;
         r_car_out <= 1'b0;
         r_blocked <= 1'b0;
         if (w_entry) begin
            if (!w_at_max) begin
               r_car_in <= 1'b1;
               if (r_ones == 4'd9) begin
                  r_ones <= 4'd0;
                  r_tens <= r_tens + 4'd1;
               end else begin
                  r_ones <= r_ones + 4'd1;
               end
            end else begin
               r_blocked <= 1'b1;
            end
         end else if (w_exit) begin
            if (!w_at_zero) begin
               r_car_out <= 1'b1;
               if (r_ones == 4'd0) begin
                  r_ones <= 4'd9;
                  r_tens <= r_tens - 4'd1;
               end else begin
                  r_ones <= r_ones - 4'd1;
               end
            end else begin
               r_blocked <= 1'b1;
            end
         end
      end
   end

   assign bus.ones    = r_ones;
   assign bus.tens    = r_tens;
   assign bus.clear   = w_at_zero;
   assign bus.full    = w_at_max;
   assign bus.car_in  = r_car_in;
   assign bus.car_out = r_car_out;
   assign bus.blocked = r_blocked;

endmodule
`default_nettype wire

// File: tb/tb_parking_lot_counter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : tb_parking_lot_counter
// Purpose: Directed self-checking bench for parking_lot_counter (MAX = 25).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tb_parking_lot_counter;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;
   int   n_in;
   int   n_out;
   int   n_blk;
   int   n_multi;

   parking_lot_counter_if bus ();

   parking_lot_counter #(.MAX(25)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clr_cnt();
      n_in  = 0;
      n_out = 0;
      n_blk = 0;
   endtask

   // Hold one sensor pattern for 3 cycles, tallying pulses seen.
   task automatic step(input logic [1:0] ab);
      bus.a = ab[1];
      bus.b = ab[0];
      repeat (3) begin
         @(posedge clk);
         #1;
         n_in  += int'(bus.car_in);
         n_out += int'(bus.car_out);
         n_blk += int'(bus.blocked);
         if ((int'(bus.car_in) + int'(bus.car_out) + int'(bus.blocked)) > 1)
            n_multi++;
      end
   endtask

   task automatic do_entry();
      step(2'b00); step(2'b10); step(2'b11); step(2'b01); step(2'b00);
   endtask

   task automatic do_exit();
      step(2'b00); step(2'b01); step(2'b11); step(2'b10); step(2'b00);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #3 reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      n_multi  = 0;
      clr_cnt();
      bus.a = 1'b0;
      bus.b = 1'b0;
      do_reset();

      // Reset state
      chk("rst_ones",  int'(bus.ones), 0);
      chk("rst_tens",  int'(bus.tens), 0);
      chk("rst_clear", int'(bus.clear), 1);
      chk("rst_full",  int'(bus.full), 0);
      chk("rst_pulse", int'(bus.car_in) + int'(bus.car_out) + int'(bus.blocked), 0);

      // Single entry
      clr_cnt();
      do_entry();
      chk("ent_car_in", n_in, 1);
      chk("ent_ones",   int'(bus.ones), 1);
      chk("ent_tens",   int'(bus.tens), 0);
      chk("ent_clear",  int'(bus.clear), 0);

      // Exit at empty is blocked
      do_reset();
      clr_cnt();
      do_exit();
      chk("exit0_blk",   n_blk, 1);
      chk("exit0_out",   n_out, 0);
      chk("exit0_ones",  int'(bus.ones), 0);
      chk("exit0_clear", int'(bus.clear), 1);

      // Decade roll-over both directions
      clr_cnt();
      for (int i = 0; i < 9; i++) do_entry();
      chk("nine_ones", int'(bus.ones), 9);
      chk("nine_tens", int'(bus.tens), 0);
      do_entry();
      chk("ten_ones", int'(bus.ones), 0);
      chk("ten_tens", int'(bus.tens), 1);
      do_exit();
      chk("dec_ones", int'(bus.ones), 9);
      chk("dec_tens", int'(bus.tens), 0);
      chk("dec_pulses", n_in * 100 + n_out, 1001);

      // Fill to capacity (9 -> 25)
      for (int i = 0; i < 16; i++) do_entry();
      chk("max_full", int'(bus.full), 1);
      chk("max_tens", int'(bus.tens), 2);
      chk("max_ones", int'(bus.ones), 5);
      chk("max_clear", int'(bus.clear), 0);
      clr_cnt();
      do_entry();
      chk("over_blk", n_blk, 1);
      chk("over_in",  n_in, 0);
      chk("over_cnt", int'(bus.tens) * 10 + int'(bus.ones), 25);
      clr_cnt();
      do_exit();
      chk("unfull_out",  n_out, 1);
      chk("unfull_full", int'(bus.full), 0);
      chk("unfull_cnt",  int'(bus.tens) * 10 + int'(bus.ones), 24);

      // Aborts and illegal jump
      clr_cnt();
      step(2'b10); step(2'b00);
      step(2'b10); step(2'b11); step(2'b10); step(2'b00);
      step(2'b10); step(2'b01); step(2'b01); step(2'b00);
      chk("abort_pulses", n_in + n_out + n_blk, 0);
      chk("abort_cnt", int'(bus.tens) * 10 + int'(bus.ones), 24);

      // Reset mid-sequence with count 7, FSM in ENT2
      do_reset();
      for (int i = 0; i < 7; i++) do_entry();
      chk("pre_rst_cnt", int'(bus.tens) * 10 + int'(bus.ones), 7);
      step(2'b00); step(2'b10); step(2'b11);
      #3 reset = 1'b1;
      #1;
      chk("arst_cnt",   int'(bus.tens) * 10 + int'(bus.ones), 0);
      chk("arst_clear", int'(bus.clear), 1);
      #7 reset = 1'b0;
      clr_cnt();
      step(2'b11); step(2'b01); step(2'b00);
      chk("tail_in",  n_in, 0);
      chk("tail_cnt", int'(bus.tens) * 10 + int'(bus.ones), 0);

      chk("exclusive_pulses", n_multi, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
